// File: rtl/ahb_ext_ram.sv
// AHB-Lite subordinate that terminates the external-bus port: a byte-writable word RAM
// with programmable wait states and a two-cycle ERROR response. Optional: AHB_EXT_RAM_RAW_BYPASS_EN.
module ahb_ext_ram #(
  parameter int                 AHBW        = 64,
  parameter int                 PA_BITS     = 56,
  parameter int                 DEPTH       = 1024,
  parameter logic [PA_BITS-1:0] BASE        = 'h8000_0000,
  parameter int                 WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 HSELEXT,
  input  logic [PA_BITS-1:0]   HADDR,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [3:0]           HPROT,
  input  logic [1:0]           HTRANS,
  input  logic                 HMASTLOCK,
  input  logic                 HREADY,
  input  logic [AHBW-1:0]      HWDATA,
  input  logic [AHBW/8-1:0]    HWSTRB,
  output logic [AHBW-1:0]      HRDATAEXT,
  output logic                 HREADYEXT,
  output logic                 HRESPEXT
);

  localparam int BYTES = AHBW / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam int LW    = PA_BITS + 1;
  localparam logic [PA_BITS:0] LIMIT   = {1'b0, BASE} + LW'(DEPTH) * LW'(BYTES);
  localparam logic [3:0]       WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // S_HAZ is only reachable when the read-after-write bypass is compiled out.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2,
    S_HAZ
  } state_t;

  state_t            state_q, state_n;
  logic [3:0]        cnt_q, cnt_n;
  logic              wr_q;
  logic [IDXW-1:0]   idx_q;
  logic [AHBW-1:0]   rd_q;
  logic [AHBW-1:0]   mem [DEPTH];

  logic              accept;
  logic              range_err;
  logic              size_err;
  logic              hazard;
  logic [PA_BITS-1:0] offset;
  logic [IDXW-1:0]   idx_now;

  logic              take;
  logic              load;
  logic              rd_en;
  logic              fwd;
  logic [IDXW-1:0]   rd_idx;
  logic              we;

  // Address-phase decode.
  assign accept    = HSELEXT & HTRANS[1] & HREADY;
  assign offset    = HADDR - BASE;
  assign idx_now   = offset[BSH +: IDXW];
  assign range_err = (HADDR < BASE) || ({1'b0, HADDR} >= LIMIT);
  assign size_err  = (HSIZE > 3'(BSH));
  assign hazard    = (state_q == S_DATA) && wr_q && !HWRITE && (idx_now == idx_q);

  // Burst type, protection, lock and the SEQ/NONSEQ distinction do not affect this RAM.
  logic unused_sink;
  assign unused_sink = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], offset};

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    HREADYEXT = 1'b1;
    HRESPEXT  = 1'b0;
    take      = 1'b0;
    load      = 1'b0;
    rd_en     = 1'b0;
    fwd       = 1'b0;
    rd_idx    = idx_q;

    case (state_q)
      S_IDLE: begin
        take = accept;
      end
      S_WAIT: begin
        HREADYEXT = 1'b0;
        if (cnt_q == 4'd0) begin
          state_n = S_DATA;
          rd_en   = !wr_q;
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      S_DATA: begin
        if (accept) take = 1'b1;
        else        state_n = S_IDLE;
      end
      S_ERR1: begin
        HREADYEXT = 1'b0;
        HRESPEXT  = 1'b1;
        state_n   = S_ERR2;
      end
      S_ERR2: begin
        HRESPEXT = 1'b1;
        if (accept) take = 1'b1;
        else        state_n = S_IDLE;
      end
      S_HAZ: begin
        // The write committed at the previous edge, so the RAM now holds the merged word.
        HREADYEXT = 1'b0;
        state_n   = S_DATA;
        rd_en     = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (take) begin
      load = 1'b1;
      if (range_err || size_err) begin
        state_n = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_n = S_WAIT;
        cnt_n   = WS_LOAD;
      end else if (hazard) begin
`ifdef AHB_EXT_RAM_RAW_BYPASS_EN
        state_n = S_DATA;
        rd_en   = 1'b1;
        fwd     = 1'b1;
        rd_idx  = idx_now;
`else
        state_n = S_HAZ;
`endif
      end else begin
        state_n = S_DATA;
        rd_en   = !HWRITE;
        rd_idx  = idx_now;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (load) begin
        wr_q  <= HWRITE;
        idx_q <= idx_now;
      end
    end
  end

  // A write in flight when reset arrives is dropped.
  assign we = (state_q == S_DATA) && wr_q && !reset;

  // NOTE: the RAM array has no reset branch; clearing it would prevent mapping to block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (HWSTRB[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Read register: loaded only for reads, so it holds its value across other cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en) begin
      for (int b = 0; b < BYTES; b++) begin
        rd_q[8*b +: 8] <= (fwd && HWSTRB[b]) ? HWDATA[8*b +: 8] : mem[rd_idx][8*b +: 8];
      end
    end
  end

  assign HRDATAEXT = rd_q;

endmodule

// File: tb/tb_ahb_ext_ram.sv
// Directed bench for ahb_ext_ram: three instances with 0, 3 and 2 wait states on a shared bus.
module tb_ahb_ext_ram;

  localparam logic [55:0] BASE = 56'h8000_0000;
`ifdef AHB_EXT_RAM_RAW_BYPASS_EN
  localparam int RAW_WAITS = 0;
`else
  localparam int RAW_WAITS = 1;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2x;
  logic        hsel, hwrite;
  logic [55:0] haddr;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  int          cur;

  wire  [2:0]  rdy, rsp;
  wire  [63:0] rd [3];
  logic        hready, hresp;
  logic [63:0] hrdata;

  assign hready = rdy[cur];
  assign hresp  = rsp[cur];
  assign hrdata = rd[cur];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_ext_ram #(
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 2)
    ) u_dut (
      .clk       (clk),
      .reset     ((g == 2) ? (rst | rst2x) : rst),
      .HSELEXT   (hsel && (cur == g)),
      .HADDR     (haddr),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HBURST    (3'b000),
      .HPROT     (4'b0000),
      .HTRANS    (htrans),
      .HMASTLOCK (1'b0),
      .HREADY    (hready),
      .HWDATA    (hwdata),
      .HWSTRB    (hwstrb),
      .HRDATAEXT (rd[g]),
      .HREADYEXT (rdy[g]),
      .HRESPEXT  (rsp[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a sampling point inside a data phase; counts HREADYEXT-low cycles.
  task automatic wait_ready(output int waits, output logic wresp);
    waits = 0;
    wresp = 1'b0;
    while (!hready && waits < 20) begin
      waits++;
      wresp = wresp | hresp;
      @(posedge clk); #1;
    end
    if (!hready) check("ready_timeout", {63'd0, hready}, 64'd1);
  endtask

  // One isolated transfer; returns the data-phase response seen on the ready cycle.
  task automatic xfer(input int d, input logic [55:0] a, input logic w, input logic [2:0] sz,
                      input logic [63:0] wd, input logic [7:0] st,
                      output int waits, output logic wresp, output logic resp,
                      output logic [63:0] data);
    cur    = d;
    hsel   = 1'b1;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = 2'b10;
    @(posedge clk); #1;
    htrans = 2'b00;
    hsel   = 1'b0;
    hwdata = wd;
    hwstrb = st;
    wait_ready(waits, wresp);
    resp = hresp;
    data = hrdata;
    @(posedge clk); #1;
  endtask

  int          w, w2;
  logic        wr, r;
  logic [63:0] d, d2;

  initial begin
    rst = 1'b1; rst2x = 1'b0; hsel = 1'b0; hwrite = 1'b0; haddr = '0; hsize = 3'd3;
    htrans = 2'b00; hwdata = '0; hwstrb = '0; cur = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cur = i; #0;
      check($sformatf("rst_ready_%0d", i), {63'd0, hready}, 64'd1);
      check($sformatf("rst_resp_%0d", i),  {63'd0, hresp},  64'd0);
      check($sformatf("rst_rdata_%0d", i), hrdata, 64'd0);
    end

    // Zero-wait write then read.
    xfer(0, BASE + 56'h8, 1'b1, 3'd3, 64'h1122334455667788, 8'hFF, w, wr, r, d);
    check("ws0_wr_waits", 64'(w), 64'd0);
    check("ws0_wr_resp",  {63'd0, r}, 64'd0);
    xfer(0, BASE + 56'h8, 1'b0, 3'd3, 64'h0, 8'h00, w, wr, r, d);
    check("ws0_rd_waits", 64'(w), 64'd0);
    check("ws0_rd_data",  d, 64'h1122334455667788);
    check("ws0_rd_resp",  {63'd0, r}, 64'd0);

    // Byte strobes clear only the low four bytes.
    xfer(0, BASE + 56'h20, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, w, wr, r, d);
    xfer(0, BASE + 56'h20, 1'b1, 3'd3, 64'h0, 8'h0F, w, wr, r, d);
    xfer(0, BASE + 56'h20, 1'b0, 3'd3, 64'h0, 8'h00, w, wr, r, d);
    check("strobe_data", d, 64'hFFFF_FFFF_0000_0000);

    // Last word of the window is legal.
    xfer(0, BASE + 56'h1FF8, 1'b1, 3'd3, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, w, wr, r, d);
    xfer(0, BASE + 56'h1FF8, 1'b0, 3'd3, 64'h0, 8'h00, w, wr, r, d);
    check("last_word_data", d, 64'hDEAD_BEEF_0BAD_F00D);
    check("last_word_resp", {63'd0, r}, 64'd0);

    // Errors: one past the window, oversized transfer, below the base.
    xfer(0, BASE + 56'h2000, 1'b0, 3'd3, 64'h0, 8'h00, w, wr, r, d);
    check("err_range_waits", 64'(w), 64'd1);
    check("err_range_err1",  {63'd0, wr}, 64'd1);
    check("err_range_err2",  {63'd0, r}, 64'd1);
    xfer(0, BASE + 56'h8, 1'b1, 3'b100, 64'h0, 8'hFF, w, wr, r, d);
    check("err_size_waits", 64'(w), 64'd1);
    check("err_size_err1",  {63'd0, wr}, 64'd1);
    check("err_size_err2",  {63'd0, r}, 64'd1);
    xfer(0, BASE - 56'h8, 1'b0, 3'd3, 64'h0, 8'h00, w, wr, r, d);
    check("err_below_resp", {63'd0, r}, 64'd1);
    xfer(0, BASE + 56'h8, 1'b0, 3'd3, 64'h0, 8'h00, w, wr, r, d);
    check("err_ram_unchanged", d, 64'h1122334455667788);

    // Read-after-write to the same word, read pipelined into the write data phase.
    xfer(0, BASE + 56'h10, 1'b1, 3'd3, 64'h1111_1111_1111_1111, 8'hFF, w, wr, r, d);
    cur = 0; hsel = 1'b1; haddr = BASE + 56'h10; hwrite = 1'b1; hsize = 3'd3; htrans = 2'b10;
    @(posedge clk); #1;
    hwdata = 64'h0000_0000_0000_00A5; hwstrb = 8'h01;
    hwrite = 1'b0; htrans = 2'b10;
    check("raw_wr_ready", {63'd0, hready}, 64'd1);
    @(posedge clk); #1;
    htrans = 2'b00; hsel = 1'b0;
    wait_ready(w, wr);
    check("raw_waits", 64'(w), 64'(RAW_WAITS));
    check("raw_data",  hrdata, 64'h1111_1111_1111_11A5);
    @(posedge clk); #1;

    // Three wait states, then back-to-back NONSEQ reads.
    xfer(1, BASE, 1'b1, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, w, wr, r, d);
    check("ws3_wr_waits", 64'(w), 64'd3);
    xfer(1, BASE + 56'h8, 1'b1, 3'd3, 64'hFEDC_BA98_7654_3210, 8'hFF, w, wr, r, d);
    xfer(1, BASE, 1'b0, 3'd3, 64'h0, 8'h00, w, wr, r, d);
    check("ws3_rd_waits", 64'(w), 64'd3);
    check("ws3_rd_data",  d, 64'h0123_4567_89AB_CDEF);
    check("ws3_wait_resp", {63'd0, wr}, 64'd0);
    cur = 1; hsel = 1'b1; haddr = BASE; hwrite = 1'b0; htrans = 2'b10;
    @(posedge clk); #1;
    haddr = BASE + 56'h8;
    wait_ready(w, wr);
    d = hrdata;
    @(posedge clk); #1;
    htrans = 2'b00; hsel = 1'b0;
    wait_ready(w2, wr);
    d2 = hrdata;
    @(posedge clk); #1;
    check("b2b_beat1_waits", 64'(w), 64'd3);
    check("b2b_beat1_data",  d, 64'h0123_4567_89AB_CDEF);
    check("b2b_beat2_waits", 64'(w2), 64'd3);
    check("b2b_beat2_data",  d2, 64'hFEDC_BA98_7654_3210);

    // Reset during the wait states of a write: old word survives.
    xfer(2, BASE + 56'h18, 1'b1, 3'd3, 64'hCAFE_F00D_1234_5678, 8'hFF, w, wr, r, d);
    xfer(2, BASE + 56'h18, 1'b0, 3'd3, 64'h0, 8'h00, w, wr, r, d);
    check("ws2_rd_waits", 64'(w), 64'd2);
    check("ws2_rd_data",  d, 64'hCAFE_F00D_1234_5678);
    cur = 2; hsel = 1'b1; haddr = BASE + 56'h18; hwrite = 1'b1; htrans = 2'b10;
    @(posedge clk); #1;
    htrans = 2'b00; hsel = 1'b0; hwdata = 64'h0; hwstrb = 8'hFF;
    check("rst_mid_in_wait", {63'd0, hready}, 64'd0);
    rst2x = 1'b1;
    @(posedge clk); #1;
    rst2x = 1'b0;
    check("rst_mid_ready", {63'd0, hready}, 64'd1);
    check("rst_mid_resp",  {63'd0, hresp},  64'd0);
    check("rst_mid_rdata", hrdata, 64'd0);
    xfer(2, BASE + 56'h18, 1'b0, 3'd3, 64'h0, 8'h00, w, wr, r, d);
    check("rst_mid_old_word", d, 64'hCAFE_F00D_1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_ext_ram.md
Name: ahb_ext_ram

Overview:
- AHB-Lite subordinate that terminates the SoC external-bus manager port (HSELEXT/HADDR/HWDATA… out; HRDATAEXT/HREADYEXT/HRESPEXT back).
- Replaces the tie-offs used today for lint and simulation wrappers.
- Provides a byte-writable word RAM with a programmable number of wait states and an AHB two-cycle ERROR response for illegal accesses.

Parameters:
- AHBW, 64, bus data width in bits (32 or 64).
- PA_BITS, 56, physical address width.
- DEPTH, 1024, RAM depth in AHBW-bit words (power of 2).
- BASE, 'h8000_0000, byte base address of the window.
- WAIT_STATES, 0, HREADYEXT-low cycles inserted per OKAY data phase (0..15).

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- HSELEXT  in  1  subordinate select
- HADDR  in  PA_BITS  address
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST  in  3  ignored (bursts handled beat by beat)
- HPROT  in  4  ignored
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus-wide ready (qualifies address phase)
- HWDATA  in  AHBW  write data (data phase)
- HWSTRB  in  AHBW/8  byte strobes (data phase)
- HRDATAEXT  out  AHBW  read data
- HREADYEXT  out  1  subordinate ready
- HRESPEXT  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous, active-high.
- Reset values: HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Address phase is accepted when HSELEXT & HTRANS[1] & HREADY at a rising edge. On acceptance, register HWRITE, word index, and an error flag.
- Word index = (HADDR-BASE) >> log2(AHBW/8), truncated to log2(DEPTH) bits.
- Error flag is set when either:
  - HADDR < BASE or HADDR >= BASE + DEPTH*AHBW/8, or
  - HSIZE > log2(AHBW/8).
- IDLE/BUSY transfers, or transfers with HSELEXT=0: no state change; the next cycle gives an OKAY zero-wait response (HREADYEXT=1, HRESPEXT=0).
- FSM states and transitions:
  - IDLE: accepted & err → ERR1; accepted & WAIT_STATES>0 → WAIT (counter=WAIT_STATES-1); accepted → DATA.
  - WAIT: HREADYEXT=0, HRESPEXT=0; counter decrements; at 0 → DATA.
  - DATA: HREADYEXT=1, HRESPEXT=0. A write commits HWDATA bytes where HWSTRB[i]=1 at the end of this cycle. A read drives the registered RAM word on HRDATAEXT. A new accepted address phase in the same cycle (pipelined) goes to ERR1/WAIT/DATA as from IDLE; otherwise → IDLE.
  - ERR1: HREADYEXT=0, HRESPEXT=1 → ERR2.
  - ERR2: HREADYEXT=1, HRESPEXT=1; no RAM access; pipelined accept allowed as in DATA; else → IDLE.
- Read latency: data is valid in the data phase. Zero-wait reads complete one cycle after the address phase, with RAM read registered at address acceptance. With wait states, the RAM is read on the last WAIT cycle.
- HRDATAEXT holds its last value outside read DATA cycles.
- RAW hazard: a write in DATA while a read to the same index is accepted → the read returns the merged (post-write) word; see optional feature.
- Reset asserted mid-transfer: transfer abandoned, pending write not committed, outputs go to reset values the next cycle.
- A manager abandoning a transfer during ERR1 by driving HTRANS=IDLE: ERR2 still completes.

Optional Feature:
- Macro AHB_EXT_RAM_RAW_BYPASS_EN.
- Defined: same-index write→read hazard is resolved by forwarding the HWSTRB-merged write data into the read register; no extra wait.
- Undefined: the hazard inserts exactly one extra HREADYEXT=0 cycle before the read DATA cycle, and the RAM is re-read after the write commits. Data returned is identical; latency is +1.

Test Plan:
- WAIT_STATES=0, AHBW=64: write 'h1122334455667788 to BASE+8 with HWSTRB='hFF, then read BASE+8 → HREADYEXT never low; HRDATAEXT='h1122334455667788, HRESPEXT=0.
- WAIT_STATES=3: read BASE → exactly 3 cycles HREADYEXT=0 then 1 OKAY cycle with data; back-to-back NONSEQ reads → 4 cycles per beat.
- Byte strobes: word='hFFFF_FFFF_FFFF_FFFF, write 'h0 with HWSTRB='h0F → readback 'hFFFF_FFFF_0000_0000.
- Error: read BASE+DEPTH*8, then a write with HSIZE=3'b100 → each gives ERR1 (HREADYEXT=0, HRESPEXT=1) then ERR2 (1,1); RAM unchanged.
- RAW: write 'hA5 (HWSTRB='h01) to BASE+0x10, immediately pipelined read BASE+0x10 → read returns low byte 'hA5. Extra wait cycle only when the macro is undefined.
- Reset asserted during WAIT of a write (WAIT_STATES=2) → next cycle HREADYEXT=1, HRESPEXT=0; subsequent read shows old word.
